// File: rtl/pla_checker.sv
// ----------------------------------------------------------------------------
// pla_checker
//   Walks a 3-input PLA through all eight input vectors in ascending order.
//   Each response {A,B,C,D} is compared against a 4-bit entry of the EXP
//   table. Mismatches are counted and recorded per vector.
//
//   Timing of one vector: APPLY (1 cycle) + WAIT (SETTLE cycles) + SAMPLE
//   (1 cycle), so SETTLE+2 cycles per vector. A run is 8 vectors plus one
//   DONE cycle.
//
// Handshake:
//   start is a level that is looked at only while the FSM is in IDLE. A high
//   level there launches a run. Any start level seen while busy is high,
//   including the DONE cycle, is ignored. There is no backpressure.
//
// Parameters:
//   SETTLE      wait cycles between applying a vector and sampling (0..15)
//   EXP         expected table, EXP[4i+3:4i] = {A,B,C,D} for vector i
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       launches a run when sampled high in IDLE
//   A,B,C,D     PLA responses under test
//   x,y,z       registered stimulus to the PLA, {x,y,z} = vector index
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle pulse in the DONE state
//   pass        last completed run had zero mismatches
//   err_cnt     mismatched vectors in the current or last run (0..8)
//   fail_mask   bit i set when vector i mismatched
//   first_fail  lowest mismatched vector index (valid when err_cnt != 0)
//   o_dbg_state current FSM state encoding, for observation only
// ----------------------------------------------------------------------------
module pla_checker #(
  parameter int unsigned SETTLE = 3,
  parameter logic [31:0] EXP    = 32'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_L  = SETTLE[3:0];
  localparam logic [3:0] ERR_MAX   = 4'd8;

  logic [2:0] r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_xyz;
  logic       r_pass;
  logic [3:0] r_err;
  logic [7:0] r_mask;
  logic [2:0] r_first;

  logic [3:0] w_exp;
  logic       w_mismatch;

  // Expected nibble for the vector currently being sampled.
  assign w_exp      = EXP[{r_idx, 2'b00} +: 4];
  assign w_mismatch = ({A, B, C, D} != w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
      r_xyz   <= 3'd0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_mask  <= 8'd0;
      r_first <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_APPLY;
            r_idx   <= 3'd0;
            // Stimulus is loaded on the edge that enters APPLY.
            r_xyz   <= 3'd0;
            r_err   <= 4'd0;
            r_mask  <= 8'd0;
            r_first <= 3'd0;
            r_pass  <= 1'b0;
          end
        end
        ST_APPLY: begin
          r_cnt   <= SETTLE_L;
          r_state <= (SETTLE_L != 4'd0) ? ST_WAIT : ST_SAMPLE;
        end
        ST_WAIT: begin
          // Counter starts at SETTLE, so WAIT lasts exactly SETTLE cycles.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_mismatch) begin
            if (r_err != ERR_MAX) begin
              r_err <= r_err + 4'd1;
            end
            r_mask[r_idx] <= 1'b1;
            if (r_err == 4'd0) begin
              r_first <= r_idx;
            end
          end
          if (r_idx == 3'd7) begin
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_xyz   <= r_idx + 3'd1;
            r_state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          r_pass  <= (r_err == 4'd0);
          r_xyz   <= 3'd0;
          r_idx   <= 3'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign {x, y, z}   = r_xyz;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign pass        = r_pass;
  assign err_cnt     = r_err;
  assign fail_mask   = r_mask;
  assign first_fail  = r_first;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pla_checker.sv
// ----------------------------------------------------------------------------
// tb_pla_checker
//   Directed bench for pla_checker. u_dut3 uses SETTLE=3 and a PLA model
//   whose behaviour is selected by mode3; u_dut0 uses SETTLE=0 with a plain
//   loopback model. Cycle numbers count clock periods after the edge that
//   samples start, the first period being cycle 1.
// ----------------------------------------------------------------------------
module tb_pla_checker;

  localparam logic [31:0] EXP_TBL = 32'hFEDCBA98;
  localparam logic [2:0]  S_WAIT   = 3'd2;
  localparam logic [2:0]  S_SAMPLE = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT with SETTLE=3 ----------------
  logic       start3;
  logic [3:0] abcd3;
  logic       x3, y3, z3, busy3, done3, pass3;
  logic [3:0] err3;
  logic [7:0] mask3;
  logic [2:0] first3, st3;
  logic [2:0] xyz3;
  assign xyz3 = {x3, y3, z3};

  pla_checker #(.SETTLE(3), .EXP(EXP_TBL)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .A(abcd3[3]), .B(abcd3[2]), .C(abcd3[1]), .D(abcd3[0]),
    .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_mask(mask3), .first_fail(first3),
    .o_dbg_state(st3)
  );

  // ---------------- DUT with SETTLE=0 ----------------
  logic       start0;
  logic [3:0] abcd0;
  logic       x0, y0, z0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [7:0] mask0;
  logic [2:0] first0, st0;
  logic [2:0] xyz0;
  assign xyz0  = {x0, y0, z0};
  assign abcd0 = {1'b1, x0, y0, z0};

  pla_checker #(.SETTLE(0), .EXP(EXP_TBL)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .A(abcd0[3]), .B(abcd0[2]), .C(abcd0[1]), .D(abcd0[0]),
    .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_mask(mask0), .first_fail(first0),
    .o_dbg_state(st0)
  );

  // ---------------- PLA model for u_dut3 ----------------
  // 0: loopback {1,x,y,z} in SAMPLE, random noise in every other state
  // 1: outputs stuck at 0
  // 2: loopback with D inverted on vector 5
  int         mode3;
  logic [3:0] noise;
  logic [3:0] lb3;

  initial begin
    noise = 4'h0;
    forever begin
      @(posedge clk);
      #2 noise = 4'($urandom_range(0, 15));
    end
  end

  always_comb begin
    lb3   = {1'b1, x3, y3, z3};
    abcd3 = lb3;
    case (mode3)
      0:       abcd3 = (st3 == S_SAMPLE) ? lb3 : noise;
      1:       abcd3 = 4'h0;
      2:       abcd3 = (xyz3 == 3'd5) ? (lb3 ^ 4'h1) : lb3;
      default: abcd3 = lb3;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_total;
  int n_bad;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int         done_cyc;
  int         n_done;
  logic [2:0] xyz_c6;
  logic [3:0] err_c1;
  logic [7:0] mask_c1;

  // Caller must be just after a negedge. Runs 60 cycles, recording the
  // cycle of the first done pulse and the number of done pulses.
  task automatic run3(input bit extra_start);
    start3   = 1'b1;
    done_cyc = -1;
    n_done   = 0;
    xyz_c6   = 3'bx;
    err_c1   = 4'bx;
    mask_c1  = 8'bx;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (c == 1) begin
        err_c1  = err3;
        mask_c1 = mask3;
      end
      if (c == 6) xyz_c6 = xyz3;
      if (extra_start && c == 10) start3 = 1'b1;
      if (done3) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        if (extra_start) start3 = 1'b1;
      end
    end
    start3 = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    start3  = 1'b0;
    start0  = 1'b0;
    mode3   = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy",  busy3,  0);
    chk("rst_done",  done3,  0);
    chk("rst_pass",  pass3,  0);
    chk("rst_err",   err3,   0);
    chk("rst_mask",  mask3,  0);
    chk("rst_first", first3, 0);
    chk("rst_xyz",   xyz3,   0);
    chk("rst_busy0", busy0,  0);

    // Start held high on the very first edge with rst_n high.
    rst_n = 1'b1;
    mode3 = 0;
    run3(1'b0);
    chk("lb_done_cyc", done_cyc, 41);
    chk("lb_n_done",   n_done,   1);
    chk("lb_xyz_c6",   xyz_c6,   1);
    chk("lb_pass",     pass3,    1);
    chk("lb_err",      err3,     0);
    chk("lb_mask",     mask3,    8'h00);
    chk("lb_busy",     busy3,    0);
    chk("lb_xyz_idle", xyz3,     0);

    mode3 = 1;
    run3(1'b0);
    chk("s0_done_cyc", done_cyc, 41);
    chk("s0_pass",     pass3,    0);
    chk("s0_err",      err3,     8);
    chk("s0_mask",     mask3,    8'hFF);
    chk("s0_first",    first3,   0);

    mode3 = 2;
    run3(1'b0);
    chk("v5_err",   err3,   1);
    chk("v5_mask",  mask3,  8'h20);
    chk("v5_first", first3, 5);
    chk("v5_pass",  pass3,  0);

    repeat (5) @(negedge clk);
    chk("hold_err",   err3,   1);
    chk("hold_mask",  mask3,  8'h20);
    chk("hold_first", first3, 5);

    // Extra start pulses while busy and during DONE must not disturb the run.
    mode3 = 0;
    run3(1'b1);
    chk("rs_err_c1",   err_c1,   0);
    chk("rs_mask_c1",  mask_c1,  8'h00);
    chk("rs_done_cyc", done_cyc, 41);
    chk("rs_n_done",   n_done,   1);
    chk("rs_pass",     pass3,    1);
    chk("rs_busy",     busy3,    0);

    // Reset during WAIT of vector 3 (cycles 17..19).
    mode3  = 1;
    start3 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start3 = 1'b0;
    end
    chk("mr_state", st3,  S_WAIT);
    chk("mr_xyz",   xyz3, 3);
    chk("mr_err",   err3, 3);
    rst_n = 1'b0;
    #1;
    chk("mr_busy",  busy3,  0);
    chk("mr_done",  done3,  0);
    chk("mr_pass",  pass3,  0);
    chk("mr_err0",  err3,   0);
    chk("mr_mask",  mask3,  0);
    chk("mr_first", first3, 0);
    chk("mr_xyz0",  xyz3,   0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done3) n_done++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done3 || busy3) n_done++;
    end
    chk("mr_quiet", n_done, 0);
    mode3 = 0;
    run3(1'b0);
    chk("mr2_done_cyc", done_cyc, 41);
    chk("mr2_pass",     pass3,    1);
    chk("mr2_err",      err3,     0);
    chk("mr2_mask",     mask3,    8'h00);

    // SETTLE=0: two cycles per vector, stimulus 0..7 in order.
    for (int c = 1; c <= 16; c++) exp_q.push_back(3'((c - 1) / 2));
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      chk("s0_xyz_seq", xyz0, exp_q.pop_front());
      chk("s0_no_done", done0, 0);
    end
    @(negedge clk);
    chk("z_done17", done0, 1);
    @(negedge clk);
    chk("z_done_off", done0, 0);
    chk("z_pass",     pass0, 1);
    chk("z_err",      err0,  0);
    chk("z_mask",     mask0, 8'h00);
    chk("z_busy",     busy0, 0);
    chk("z_xyz_idle", xyz0,  0);
    chk("z_q_empty",  exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
